pulse_scheduler: RTL and testbench



---
 rtl/pulse_scheduler_pkg.sv | 10 +
 rtl/pulse_scheduler_rr_arbiter.sv | 30 +++
 rtl/pulse_scheduler.sv | 99 +++++++++
 tb/tb_pulse_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pulse_scheduler_pkg.sv
// pulse_scheduler_pkg: shared state encodings and default sizes for the pulse scheduler.
package pulse_scheduler_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t HIGH = 2'd1;
    localparam state_t LOW  = 2'd2;
    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 8;
    localparam int RW_DEF    = 4;
endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot winner scanning upward from pointer with wrap.
// PULSE_SCHED_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);
`ifdef PULSE_SCHED_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = ^pointer;
    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (enable && !(|winner) && req[i]) winner[i] = 1'b1;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (enable && !(|winner) && req[(int'(pointer) + i) % N_REQ])
                winner[(int'(pointer) + i) % N_REQ] = 1'b1;
    end
`endif
    assign valid = |winner;
endmodule

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: arbitrates N_REQ requesters onto one shared pulse-train generator.
// Define PULSE_SCHED_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*CW-1:0] high_len,
    input  logic [N_REQ*CW-1:0] low_len,
    input  logic [N_REQ*RW-1:0] rep_cnt,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               signal,
    output logic               busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    state_t state;
    logic [PW-1:0] ptr, idx, win_idx, next_ptr;
    logic [CW-1:0] h, l, cnt, hs, ls;
    logic [RW-1:0] rc, rs;
    logic [N_REQ-1:0] winner;
    logic valid;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req(req), .pointer(ptr), .enable(state == IDLE), .winner(winner), .valid(valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (winner[i]) win_idx = PW'(i);
    end

    // zero-length fields behave as length one
    assign hs = (high_len[int'(win_idx)*CW +: CW] == '0) ? CW'(1) : high_len[int'(win_idx)*CW +: CW];
    assign ls = (low_len[int'(win_idx)*CW +: CW] == '0) ? CW'(1) : low_len[int'(win_idx)*CW +: CW];
    assign rs = (rep_cnt[int'(win_idx)*RW +: RW] == '0) ? RW'(1) : rep_cnt[int'(win_idx)*RW +: RW];
`ifdef PULSE_SCHED_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (idx == PW'(N_REQ-1)) ? '0 : idx + 1'b1;
`endif
    assign busy = |grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            signal <= 1'b0;
            ptr    <= '0;
            idx    <= '0;
            h      <= '0;
            l      <= '0;
            cnt    <= '0;
            rc     <= '0;
        end else begin
            done <= '0;
            if (state == IDLE) begin
                if (valid) begin
                    state  <= HIGH;
                    grant  <= winner;
                    signal <= 1'b1;
                    idx    <= win_idx;
                    h      <= hs;
                    l      <= ls;
                    cnt    <= hs;
                    rc     <= rs;
                end
            end else if (!(|(req & grant))) begin
                state  <= IDLE;
                grant  <= '0;
                signal <= 1'b0;
                ptr    <= next_ptr;
            end else if (cnt != CW'(1)) begin
                cnt <= cnt - 1'b1;
            end else if (state == HIGH) begin
                state  <= LOW;
                signal <= 1'b0;
                cnt    <= l;
            end else if (rc != RW'(1)) begin
                state  <= HIGH;
                signal <= 1'b1;
                cnt    <= h;
                rc     <= rc - 1'b1;
            end else begin
                state <= IDLE;
                grant <= '0;
                done  <= grant;
                ptr   <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_pulse_scheduler.sv
// tb_pulse_scheduler: directed vector table plus hand-written arbitration, abort and reset sequences.
module tb_pulse_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] high_len, low_len;
    logic [15:0] rep_cnt;
    logic [3:0]  grant, done;
    logic        signal, busy;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] h, l;
        logic [3:0] r;
        int         he, le, tot;
    } vec_t;
    vec_t vt[6];

    pulse_scheduler dut (
        .clock(clock), .reset(reset), .req(req), .high_len(high_len), .low_len(low_len),
        .rep_cnt(rep_cnt), .grant(grant), .done(done), .signal(signal), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic set_cfg(input int i, input logic [7:0] h, input logic [7:0] l, input logic [3:0] r);
        high_len[i*8 +: 8] = h;
        low_len[i*8 +: 8]  = l;
        rep_cnt[i*4 +: 4]  = r;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_signal"}, signal, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{0, 8'd3, 8'd2, 4'd2, 3, 2, 10};
        vt[1] = '{2, 8'd0, 8'd0, 4'd0, 1, 1, 2};
        vt[2] = '{1, 8'd1, 8'd4, 4'd3, 1, 4, 15};
        vt[3] = '{3, 8'd7, 8'd1, 4'd1, 7, 1, 8};
        vt[4] = '{2, 8'd2, 8'd3, 4'd0, 2, 3, 5};
        vt[5] = '{1, 8'd2, 8'd0, 4'd0, 2, 1, 3};
        reset = 1'b1;
        req = '0;
        high_len = '0;
        low_len = '0;
        rep_cnt = '0;
        repeat (2) @(negedge clock);
        chk_idle("reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk_idle("noreq");

        for (int v = 0; v < 6; v++) begin
            set_cfg(vt[v].idx, vt[v].h, vt[v].l, vt[v].r);
            req = 4'(1 << vt[v].idx);
            for (int t = 0; t < vt[v].tot; t++) begin
                @(negedge clock);
                chk($sformatf("v%0d_sig%0d", v, t), signal, 32'((t % (vt[v].he + vt[v].le)) < vt[v].he));
                chk($sformatf("v%0d_gnt%0d", v, t), grant, 1 << vt[v].idx);
                chk($sformatf("v%0d_busy%0d", v, t), busy, 1);
                chk($sformatf("v%0d_nodone%0d", v, t), done, 0);
                if (t == 0) set_cfg(vt[v].idx, 8'd9, 8'd9, 4'd9);
            end
            @(negedge clock);
            chk($sformatf("v%0d_done", v), done, 1 << vt[v].idx);
            chk($sformatf("v%0d_endgnt", v), grant, 0);
            chk($sformatf("v%0d_endsig", v), signal, 0);
            req = '0;
            @(negedge clock);
            chk_idle($sformatf("v%0d_after", v));
        end

        // asynchronous reset in the middle of a HIGH phase
        for (int i = 0; i < 4; i++) set_cfg(i, 8'd1, 8'd1, 4'd1);
        set_cfg(2, 8'd5, 8'd5, 4'd1);
        req = 4'b0100;
        @(negedge clock);
        chk("arst_pre_gnt", grant, 4'b0100);
        #2 reset = 1'b1;
        #1 chk_idle("arst");
        @(negedge clock);
        chk_idle("arst_held");
        set_cfg(2, 8'd1, 8'd1, 4'd1);
        req = 4'b1111;
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
`ifdef PULSE_SCHED_FIXED_PRIO_EN
            chk($sformatf("fp_all_gnt%0d", k), grant, (k % 3 == 2) ? 0 : 1);
            chk($sformatf("fp_all_done%0d", k), done, (k % 3 == 2) ? 1 : 0);
`else
            chk($sformatf("rr_gnt%0d", k), grant, (k % 3 == 2) ? 0 : 1 << ((k / 3) % 4));
            chk($sformatf("rr_done%0d", k), done, (k % 3 == 2) ? 1 << ((k / 3) % 4) : 0);
`endif
        end
        req = '0;
        pulse_reset();

        // abort: requester 1 drops req in its third HIGH cycle
        set_cfg(1, 8'd5, 8'd5, 4'd3);
        set_cfg(3, 8'd1, 8'd1, 4'd1);
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("ab_gnt%0d", k), grant, 4'b0010);
            chk($sformatf("ab_sig%0d", k), signal, 1);
        end
        req = 4'b1000;
        @(negedge clock);
        chk_idle("ab_abort");
        @(negedge clock);
        chk("ab_next_gnt", grant, 4'b1000);
        chk("ab_next_sig", signal, 1);
        @(negedge clock);
        chk("ab_next_low", signal, 0);
        @(negedge clock);
        chk("ab_next_done", done, 4'b1000);
        req = '0;
        pulse_reset();

        // two contenders held: rr alternates, fixed priority keeps requester 1
        set_cfg(1, 8'd1, 8'd1, 4'd1);
        req = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
`ifdef PULSE_SCHED_FIXED_PRIO_EN
            chk($sformatf("pr_gnt%0d", k), grant, (k % 3 == 2) ? 0 : 4'b0010);
`else
            chk($sformatf("pr_gnt%0d", k), grant, (k % 3 == 2) ? 0 : (k < 3 ? 4'b0010 : 4'b1000));
`endif
        end
        req = 4'b1000;
        @(negedge clock);
        chk("pr_last_gnt", grant, 4'b1000);
        req = '0;
        @(negedge clock);
        chk_idle("pr_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
